// File: rtl/aes_sched_if.sv
// rtl/aes_sched_if.sv - request/response handshake bundle for the AES scheduler
interface aes_sched_if #(
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [127:0]     req0_data;
  logic [127:0]     req0_key;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid;
  logic             req1_ready;
  logic [127:0]     req1_data;
  logic [127:0]     req1_key;
  logic [TAG_W-1:0] req1_tag;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [127:0]     rsp0_data;
  logic [TAG_W-1:0] rsp0_tag;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [127:0]     rsp1_data;
  logic [TAG_W-1:0] rsp1_tag;

  modport master (
    output req0_valid, req0_data, req0_key, req0_tag,
    output req1_valid, req1_data, req1_key, req1_tag,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_tag,
    input  rsp1_valid, rsp1_data, rsp1_tag,
    output rsp0_ready, rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req0_key, req0_tag,
    input  req1_valid, req1_data, req1_key, req1_tag,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_tag,
    output rsp1_valid, rsp1_data, rsp1_tag,
    input  rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/aes_sched.sv
// rtl/aes_sched.sv - two-requester credit-based scheduler for a fixed-latency cipher core
module aes_sched #(
  parameter int CORE_LAT   = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  aes_sched_if.slave   bus,
  output logic [127:0] core_datain,
  output logic [127:0] core_key,
  input  logic [127:0] core_dataout,
  output logic         busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  logic             prio_q, prio_d;
  logic [CNT_W-1:0] infl_q, infl_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [127:0]     din_q, key_q;
  logic [CORE_LAT:0] tv_q, tid_q;
  logic [TAG_W-1:0] ttag_q [CORE_LAT+1];
  logic [127:0]     fdata_q [FIFO_DEPTH];
  logic             fid_q   [FIFO_DEPTH];
  logic [TAG_W-1:0] ftag_q  [FIFO_DEPTH];

  logic             gnt_id, credit, accept, push, pop, empty, head_id;
  logic [127:0]     gnt_data, gnt_key;
  logic [TAG_W-1:0] gnt_tag;

  // Credit covers both in-flight and queued results so a FIFO write never stalls;
  // rst_n gating keeps ready low from the instant reset falls.
  always_comb begin
    gnt_id   = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
    credit   = rst_n && (({1'b0, infl_q} + {1'b0, fcnt_q}) < DEPTH_C);
    accept   = credit && (bus.req0_valid || bus.req1_valid);
    gnt_data = gnt_id ? bus.req1_data : bus.req0_data;
    gnt_key  = gnt_id ? bus.req1_key  : bus.req0_key;
    gnt_tag  = gnt_id ? bus.req1_tag  : bus.req0_tag;
    bus.req0_ready = accept && !gnt_id;
    bus.req1_ready = accept && gnt_id;

    empty   = (fcnt_q == '0);
    head_id = fid_q[rptr_q];
    bus.rsp0_valid = !empty && !head_id;
    bus.rsp1_valid = !empty && head_id;
    bus.rsp0_data  = fdata_q[rptr_q];
    bus.rsp1_data  = fdata_q[rptr_q];
    bus.rsp0_tag   = ftag_q[rptr_q];
    bus.rsp1_tag   = ftag_q[rptr_q];
    pop  = (bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready);
    push = tv_q[CORE_LAT];

    prio_d = accept ? !gnt_id : prio_q;
    case ({accept, push})
      2'b10:   infl_d = infl_q + CNT_W'(1);
      2'b01:   infl_d = infl_q - CNT_W'(1);
      default: infl_d = infl_q;
    endcase
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - CNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
      infl_q <= '0;
      fcnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      din_q  <= '0;
      key_q  <= '0;
      tv_q   <= '0;
    end else begin
      prio_q <= prio_d;
      infl_q <= infl_d;
      fcnt_q <= fcnt_d;
      tv_q   <= {tv_q[CORE_LAT-1:0], accept};
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      if (accept) begin
        din_q <= gnt_data;
        key_q <= gnt_key;
      end
    end
  end

  // Payload side of tracking and FIFO storage needs no reset: qualified by tv_q / fcnt_q.
  always_ff @(posedge clk) begin
    tid_q     <= {tid_q[CORE_LAT-1:0], gnt_id};
    ttag_q[0] <= gnt_tag;
    for (int i = 1; i <= CORE_LAT; i++) ttag_q[i] <= ttag_q[i-1];
    if (push) begin
      fdata_q[wptr_q] <= core_dataout;
      fid_q[wptr_q]   <= tid_q[CORE_LAT];
      ftag_q[wptr_q]  <= ttag_q[CORE_LAT];
    end
  end

  assign core_datain = din_q;
  assign core_key    = key_q;
  assign busy        = (infl_q != '0) || (fcnt_q != '0);
endmodule
